fp16_adder_arbiter: RTL and testbench

//  Shares one pipelined fp16 adder/subtractor (FPAddSub, operation pin exposed) among NREQ requesters.

---
 rtl/fp16_adder_arbiter_if.sv | 41 ++++
 rtl/fp16_adder_arbiter.sv | 122 ++++++++++++
 tb/tb_fp16_adder_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp16_adder_arbiter_if.sv
// Bus bundle between the fp16 adder arbiter, its requesters and the shared
// FPAddSub instance.
//   hold                 1 = no new grant this cycle
//   req_valid/req_ready  per-requester handshake (ready is one-hot)
//   req_a/req_b/req_op   packed operands and opcode, requester i at [i*DWIDTH +: DWIDTH]
//   add_a/add_b/add_op   registered operands driven into FPAddSub
//   add_result           FPAddSub result
//   rsp_valid/id/data    shared response bus, one-cycle valid pulse
//   issue_cnt            wrapping count of accepted requests
// slave  : the arbiter side.
// master : the requester / adder side.
interface fp16_adder_arbiter_if #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned IDW    = 2,
    parameter int unsigned DWIDTH = 16
);
    logic                     hold;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*DWIDTH-1:0]   req_a;
    logic [NREQ*DWIDTH-1:0]   req_b;
    logic [NREQ-1:0]          req_op;
    logic [DWIDTH-1:0]        add_a;
    logic [DWIDTH-1:0]        add_b;
    logic                     add_op;
    logic [DWIDTH-1:0]        add_result;
    logic                     rsp_valid;
    logic [IDW-1:0]           rsp_id;
    logic [DWIDTH-1:0]        rsp_data;
    logic [15:0]              issue_cnt;

    modport slave (
        input  hold, req_valid, req_a, req_b, req_op, add_result,
        output req_ready, add_a, add_b, add_op, rsp_valid, rsp_id, rsp_data, issue_cnt
    );

    modport master (
        output hold, req_valid, req_a, req_b, req_op, add_result,
        input  req_ready, add_a, add_b, add_op, rsp_valid, rsp_id, rsp_data, issue_cnt
    );
endinterface

// File: rtl/fp16_adder_arbiter.sv
// Round-robin arbiter sharing one pipelined fp16 adder/subtractor among
// NREQ requesters. One request is granted per cycle, its operands are
// registered onto the adder inputs, and the requester ID travels down a
// tag pipeline of ADD_LATENCY+1 stages so the adder result can be returned
// on the shared response bus with the right owner ID.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    fp16_adder_arbiter_if.slave (requests, adder link, responses, counter)
// The interface instance must be built with the same NREQ/IDW/DWIDTH.
// IDW must equal clog2(NREQ).
module fp16_adder_arbiter #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned IDW         = 2,
    parameter int unsigned ADD_LATENCY = 4,
    parameter int unsigned DWIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    fp16_adder_arbiter_if.slave  bus
);

    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    winner;
    logic [IDW-1:0]    cand;
    logic [IDW-1:0]    next_ptr;
    logic              found;
    logic              accept;
    logic [NREQ-1:0]   ready;

    logic [DWIDTH-1:0] a_arr [NREQ];
    logic [DWIDTH-1:0] b_arr [NREQ];

    logic [ADD_LATENCY:0] tag_vld;
    logic [IDW-1:0]       tag_id [ADD_LATENCY+1];

    logic [DWIDTH-1:0] add_a_q;
    logic [DWIDTH-1:0] add_b_q;
    logic              add_op_q;
    logic              rsp_valid_q;
    logic [IDW-1:0]    rsp_id_q;
    logic [DWIDTH-1:0] rsp_data_q;
    logic [15:0]       issue_cnt_q;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr[g] = bus.req_a[g*DWIDTH +: DWIDTH];
        assign b_arr[g] = bus.req_b[g*DWIDTH +: DWIDTH];
    end

    // Scan from rr_ptr upward, wrapping modulo NREQ; first valid wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand = IDW'((32'(rr_ptr) + off) % NREQ);
            if (!found && bus.req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Reset gates ready so nothing can handshake while reset is held.
    assign accept   = found & ~bus.hold & reset;
    assign next_ptr = IDW'((32'(winner) + 1) % NREQ);

    always_comb begin
        ready = '0;
        if (accept) begin
            ready[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr      <= '0;
            tag_vld     <= '0;
            tag_id      <= '{default: '0};
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_op_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            issue_cnt_q <= '0;
        end else begin
            if (accept) begin
                add_a_q     <= a_arr[winner];
                add_b_q     <= b_arr[winner];
                add_op_q    <= bus.req_op[winner];
                rr_ptr      <= next_ptr;
                issue_cnt_q <= issue_cnt_q + 16'd1;
            end

            // Tag pipeline never stalls; the id of an empty stage is don't-care.
            tag_vld   <= {tag_vld[ADD_LATENCY-1:0], accept};
            tag_id[0] <= winner;
            for (int unsigned k = 1; k <= ADD_LATENCY; k++) begin
                tag_id[k] <= tag_id[k-1];
            end

            if (tag_vld[ADD_LATENCY]) begin
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= tag_id[ADD_LATENCY];
                rsp_data_q  <= bus.add_result;
            end else begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.add_op    = add_op_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_fp16_adder_arbiter.sv
module tb_fp16_adder_arbiter;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned IDW    = 2;
    localparam int unsigned LAT    = 4;
    localparam int unsigned DWIDTH = 16;

    logic clk;
    logic reset;

    fp16_adder_arbiter_if #(.NREQ(NREQ), .IDW(IDW), .DWIDTH(DWIDTH)) bus ();

    fp16_adder_arbiter #(
        .NREQ(NREQ), .IDW(IDW), .ADD_LATENCY(LAT), .DWIDTH(DWIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- fp16 adder model (LAT-stage pipeline) ----------------
    function automatic real pow2(input int e);
        real r;
        r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        real m;
        int  e;
        e = int'(h[14:10]);
        m = real'(int'(h[9:0])) / 1024.0;
        if (e == 0) m = m * pow2(-14);
        else        m = (1.0 + m) * pow2(e - 15);
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] r2h(input real r);
        logic s;
        real  x;
        int   e;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        x = s ? -r : r;
        if (x > 65504.0) return {s, 15'h7C00};
        if (x < pow2(-14)) return {s, 15'h0000};
        e = 15;
        while (x >= 2.0) begin x = x / 2.0; e++; end
        while (x < 1.0)  begin x = x * 2.0; e--; end
        return {s, 5'(e), 10'($rtoi((x - 1.0) * 1024.0))};
    endfunction

    logic [15:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= r2h(bus.add_op ? h2r(bus.add_a) - h2r(bus.add_b)
                                  : h2r(bus.add_a) + h2r(bus.add_b));
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign bus.add_result = pipe[LAT-1];

    // ---------------- response monitor ----------------
    typedef struct {
        logic [IDW-1:0] id;
        logic [15:0]    data;
        int             cyc;
    } rsp_t;

    rsp_t rsp_log[$];
    bit   log_en;
    int   cyc;

    always @(posedge clk) cyc = cyc + 1;
    always @(negedge clk) begin
        if (log_en && bus.rsp_valid) rsp_log.push_back('{bus.rsp_id, bus.rsp_data, cyc});
    end

    // ---------------- checking ----------------
    int n_pass;
    int n_total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [NREQ-1:0] onehot(input int unsigned i);
        logic [NREQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic op);
        bus.req_a[i*DWIDTH +: DWIDTH] = a;
        bus.req_b[i*DWIDTH +: DWIDTH] = b;
        bus.req_op[i] = op;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        int unsigned idx;
        logic [15:0] a;
        logic [15:0] b;
        logic        op;
        logic [15:0] res;
    } vec_t;

    vec_t vecs[8];

    logic [15:0] exp_t3 [NREQ];
    logic [NREQ-1:0] exp_t4 [3];

    initial begin
        int n;
        bit seen;

        vecs[0] = '{0, 16'h3C00, 16'h4000, 1'b0, 16'h4200};  // 1+2 = 3
        vecs[1] = '{2, 16'h4200, 16'h3C00, 1'b1, 16'h4000};  // 3-1 = 2
        vecs[2] = '{1, 16'h4000, 16'h4000, 1'b0, 16'h4400};  // 2+2 = 4
        vecs[3] = '{3, 16'h3C00, 16'h4000, 1'b1, 16'hBC00};  // 1-2 = -1
        vecs[4] = '{0, 16'h3800, 16'h3800, 1'b0, 16'h3C00};  // .5+.5 = 1
        vecs[5] = '{1, 16'h4500, 16'h4500, 1'b1, 16'h0000};  // 5-5 = 0
        vecs[6] = '{3, 16'hC000, 16'h4200, 1'b0, 16'h3C00};  // -2+3 = 1
        vecs[7] = '{2, 16'h3E00, 16'h3E00, 1'b0, 16'h4200};  // 1.5+1.5 = 3

        n_pass = 0; n_total = 0; cyc = 0; log_en = 1'b1;
        reset = 1'b1;
        bus.hold = 1'b0; bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
        #1 reset = 1'b0;

        // Reset state, with every requester asking.
        repeat (2) @(negedge clk);
        bus.req_valid = '1;
        #1;
        check("rst_ready",     32'(bus.req_ready), 32'h0);
        check("rst_add_a",     32'(bus.add_a),     32'h0);
        check("rst_add_b",     32'(bus.add_b),     32'h0);
        check("rst_add_op",    32'(bus.add_op),    32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_rsp_id",    32'(bus.rsp_id),    32'h0);
        check("rst_rsp_data",  32'(bus.rsp_data),  32'h0);
        check("rst_issue_cnt", 32'(bus.issue_cnt), 32'h0);
        bus.req_valid = '0;
        @(negedge clk);
        reset = 1'b1;

        // Table of single transactions: grant, latency, owner, result.
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            set_req(int'(vecs[v].idx), vecs[v].a, vecs[v].b, vecs[v].op);
            bus.req_valid = onehot(vecs[v].idx);
            #1 check($sformatf("vec%0d_ready", v), 32'(bus.req_ready), 32'(onehot(vecs[v].idx)));
            @(posedge clk);
            #1 bus.req_valid = '0;
            n = 0; seen = 1'b0;
            while (!seen && n < 20) begin
                @(negedge clk);
                n++;
                if (bus.rsp_valid) seen = 1'b1;
            end
            check($sformatf("vec%0d_latency", v), 32'(n), 32'(LAT + 2));
            check($sformatf("vec%0d_id", v), 32'(bus.rsp_id), 32'(vecs[v].idx));
            check($sformatf("vec%0d_data", v), 32'(bus.rsp_data), 32'(vecs[v].res));
        end
        #1 check("table_issue_cnt", 32'(bus.issue_cnt), 32'd8);

        // All requesters valid for 8 cycles from reset.
        do_reset();
        rsp_log.delete();
        set_req(0, 16'h3C00, 16'h3C00, 1'b0); exp_t3[0] = 16'h4000;  // 1+1
        set_req(1, 16'h4400, 16'h3C00, 1'b1); exp_t3[1] = 16'h4200;  // 4-1
        set_req(2, 16'h3800, 16'h3800, 1'b0); exp_t3[2] = 16'h3C00;  // .5+.5
        set_req(3, 16'h4200, 16'h3C00, 1'b0); exp_t3[3] = 16'h4400;  // 3+1
        @(negedge clk);
        bus.req_valid = '1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            #1 check($sformatf("rr_all_grant%0d", c), 32'(bus.req_ready), 32'(onehot(c % NREQ)));
        end
        @(negedge clk);
        bus.req_valid = '0;
        #1 check("rr_all_issue_cnt", 32'(bus.issue_cnt), 32'd8);
        repeat (LAT + 4) @(negedge clk);
        check("rr_all_rsp_count", 32'(rsp_log.size()), 32'd8);
        for (int k = 0; k < 8 && k < rsp_log.size(); k++) begin
            check($sformatf("rr_all_rsp%0d_id", k), 32'(rsp_log[k].id), 32'(k % NREQ));
            check($sformatf("rr_all_rsp%0d_data", k), 32'(rsp_log[k].data), 32'(exp_t3[k % NREQ]));
            if (k > 0)
                check($sformatf("rr_all_rsp%0d_gap", k), 32'(rsp_log[k].cyc - rsp_log[k-1].cyc), 32'd1);
        end

        // Pointer at 3 with only req1/req3 valid: 3, 1 (wrap), 3.
        @(negedge clk);
        set_req(2, 16'h3C00, 16'h3C00, 1'b0);
        bus.req_valid = 4'b0100;
        @(posedge clk);
        #1 bus.req_valid = '0;
        exp_t4[0] = onehot(3); exp_t4[1] = onehot(1); exp_t4[2] = onehot(3);
        @(negedge clk);
        bus.req_valid = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            #1 check($sformatf("wrap_grant%0d", c), 32'(bus.req_ready), 32'(exp_t4[c]));
        end
        @(negedge clk);
        bus.req_valid = '0;
        repeat (LAT + 4) @(negedge clk);

        // hold=1 for 3 cycles with two ops in flight and req0 pending.
        rsp_log.delete();
        set_req(1, 16'h3C00, 16'h3C00, 1'b0);  // 2.0
        set_req(2, 16'h4400, 16'h3800, 1'b1);  // 3.5
        set_req(0, 16'h4000, 16'h4200, 1'b0);  // 5.0
        @(negedge clk);
        bus.req_valid = 4'b0110;
        #1 check("hold_pre_grant1", 32'(bus.req_ready), 32'(onehot(1)));
        @(negedge clk);
        #1 check("hold_pre_grant2", 32'(bus.req_ready), 32'(onehot(2)));
        @(negedge clk);
        bus.req_valid = 4'b0001;
        bus.hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            #1 check($sformatf("hold_ready%0d", c), 32'(bus.req_ready), 32'h0);
        end
        @(negedge clk);
        bus.hold = 1'b0;
        #1 check("hold_release_grant", 32'(bus.req_ready), 32'(onehot(0)));
        @(posedge clk);
        #1 bus.req_valid = '0;
        repeat (LAT + 4) @(negedge clk);
        check("hold_rsp_count", 32'(rsp_log.size()), 32'd3);
        if (rsp_log.size() >= 3) begin
            check("hold_rsp0_id",   32'(rsp_log[0].id),   32'd1);
            check("hold_rsp0_data", 32'(rsp_log[0].data), 32'h4000);
            check("hold_rsp1_id",   32'(rsp_log[1].id),   32'd2);
            check("hold_rsp1_data", 32'(rsp_log[1].data), 32'h4300);
            check("hold_rsp2_id",   32'(rsp_log[2].id),   32'd0);
            check("hold_rsp2_data", 32'(rsp_log[2].data), 32'h4500);
        end

        // Reset pulse with three ops in flight.
        @(negedge clk);
        bus.req_valid = 4'b0111;
        repeat (3) @(posedge clk);
        #1 bus.req_valid = '0;
        @(negedge clk);
        rsp_log.delete();
        reset = 1'b0;
        bus.req_valid = '1;
        #1;
        check("mid_rst_ready",     32'(bus.req_ready), 32'h0);
        check("mid_rst_add_a",     32'(bus.add_a),     32'h0);
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("mid_rst_rsp_data",  32'(bus.rsp_data),  32'h0);
        check("mid_rst_issue_cnt", 32'(bus.issue_cnt), 32'h0);
        @(negedge clk);
        bus.req_valid = '0;
        reset = 1'b1;
        repeat (LAT + 6) @(negedge clk);
        check("mid_rst_no_rsp", 32'(rsp_log.size()), 32'd0);
        set_req(0, 16'h3C00, 16'h4000, 1'b0);
        bus.req_valid = '1;
        #1 check("mid_rst_first_grant", 32'(bus.req_ready), 32'(onehot(0)));
        @(posedge clk);
        #1 bus.req_valid = '0;
        repeat (LAT + 4) @(negedge clk);
        check("mid_rst_after_count", 32'(rsp_log.size()), 32'd1);
        if (rsp_log.size() >= 1) begin
            check("mid_rst_after_id",   32'(rsp_log[0].id),   32'd0);
            check("mid_rst_after_data", 32'(rsp_log[0].data), 32'h4200);
        end

        // 65536 accepts: counter wraps to zero.
        do_reset();
        log_en = 1'b0;
        @(negedge clk);
        bus.req_valid = '1;
        repeat (65535) @(posedge clk);
        #1 check("cnt_ffff", 32'(bus.issue_cnt), 32'h0000FFFF);
        @(posedge clk);
        #1 bus.req_valid = '0;
        check("cnt_wrap", 32'(bus.issue_cnt), 32'h0);
        log_en = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
